// File: rtl/axi2axis_pkg.sv
// ============================================================================
// Module  : axi2axis_pkg
// Brief   : Shared types and constants for the axis2axi_rx read responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi2axis_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

  localparam logic [3:0] RX_DATA_ADDR   = 4'h0;
  localparam logic [3:0] RX_STATUS_ADDR = 4'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axis2axi_rx_if.sv
// ============================================================================
// Module  : axis2axi_rx_if
// Brief   : AXI4-Lite read channel plus inbound AXI-Stream bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axis2axi_rx_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready, s_axis_tdata, s_axis_tvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axis_tready
  );

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready, s_axis_tdata, s_axis_tvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axis_tready
  );
endinterface

`default_nettype wire

// File: rtl/axis_rx_fifo.sv
// ============================================================================
// Module  : axis_rx_fifo
// Brief   : Power-of-2 synchronous FIFO with head-word lookahead and count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_rx_fifo #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  wire logic              aclk,
  input  wire logic              areset,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic [DATA_W-1:0] din,
  output logic      [DATA_W-1:0] head,
  output logic      [CNT_W-1:0]  count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Storage is flushed logically through the pointers, so it needs no reset.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis2axi_rx.sv
// ============================================================================
// Module  : axis2axi_rx
// Brief   : AXI4-Lite read responder draining an inbound AXI-Stream FIFO.
//           Optional macro AXI2AXIS_RX_UNDERFLOW_ERR_EN: empty data read -> SLVERR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis2axi_rx
  import axi2axis_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  wire logic      aclk,
  input  wire logic      areset,
  axis2axi_rx_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  rd_state_t         r_state;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rvalid;

  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_arready;
  logic              w_tready;
  logic              w_push;
  logic              w_pop;
  logic              w_pop_sel;
  logic [DATA_W-1:0] w_resp_data;
  logic [1:0]        w_resp_code;
  logic [DATA_W-1:0] w_status;

  assign w_arready = (r_state == IDLE) && !areset;
  assign w_tready  = !w_full && !areset;
  assign w_push    = bus.s_axis_tvalid && w_tready;
  assign w_pop     = bus.s_axi_arvalid && w_arready && w_pop_sel;

  axis_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (w_push),
    .pop    (w_pop),
    .din    (bus.s_axis_tdata),
    .head   (w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_comb begin
    w_status                 = '0;
    w_status[DATA_W-1]       = !w_empty;
    w_status[CNT_W-1:0]      = w_count;
    w_resp_data              = '0;
    w_resp_code              = RESP_OKAY;
    w_pop_sel                = 1'b0;
    if (bus.s_axi_araddr[31:4] != '0) begin
      w_resp_code = RESP_SLVERR;
    end else begin
      case (bus.s_axi_araddr[3:0])
        RX_DATA_ADDR: begin
          if (!w_empty) begin
            w_resp_data = w_head;
            w_pop_sel   = 1'b1;
          end else begin
`ifdef AXI2AXIS_RX_UNDERFLOW_ERR_EN
            w_resp_code = RESP_SLVERR;
`else
            w_resp_code = RESP_OKAY;
`endif
          end
        end
        RX_STATUS_ADDR: w_resp_data = w_status;
        default:        w_resp_code = RESP_SLVERR;
      endcase
    end
  end

  // Response is captured at AR accept and held until the R handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.s_axi_arvalid) begin
            r_rdata  <= w_resp_data;
            r_rresp  <= w_resp_code;
            r_rvalid <= 1'b1;
            r_state  <= RESP;
          end
        end
        RESP: begin
          if (bus.s_axi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_rvalid <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_axi_arready = w_arready;
  assign bus.s_axi_rvalid  = r_rvalid;
  assign bus.s_axi_rdata   = r_rdata;
  assign bus.s_axi_rresp   = r_rresp;
  assign bus.s_axis_tready = w_tready;

endmodule

`default_nettype wire

// File: tb/tb_axis2axi_rx.sv
// ============================================================================
// Module  : tb_axis2axi_rx
// Brief   : Self-checking bench for axis2axi_rx with a queue-based reference.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis2axi_rx;
  localparam int DEPTH = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI2AXIS_RX_UNDERFLOW_ERR_EN
  localparam logic [1:0] EMPTY_RESP = SLVERR;
`else
  localparam logic [1:0] EMPTY_RESP = OKAY;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  axis2axi_rx_if #(.DATA_W(32)) bus ();

  axis2axi_rx #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: FIFO contents as a queue, plus the one outstanding response.
  logic [31:0] mq[$];
  bit          m_busy;
  logic [31:0] m_d;
  logic [1:0]  m_r;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      mq.delete();
      m_busy = 0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.s_axis_tvalid && (mq.size() < DEPTH);
      do_pop  = 0;
      if (m_busy) begin
        if (bus.s_axi_rready) m_busy = 0;
      end else if (bus.s_axi_arvalid) begin
        m_busy = 1;
        m_d = 32'h0;
        m_r = OKAY;
        if (bus.s_axi_araddr == 32'h0) begin
          if (mq.size() > 0) begin
            m_d = mq[0];
            do_pop = 1;
          end else begin
            m_r = EMPTY_RESP;
          end
        end else if (bus.s_axi_araddr == 32'h4) begin
          m_d = ((mq.size() > 0) ? 32'h8000_0000 : 32'h0) | 32'(mq.size());
        end else begin
          m_r = SLVERR;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(bus.s_axis_tdata);
    end
  end

  always @(negedge aclk) begin
    if (areset) begin
      chk("rst_arready", {31'b0, bus.s_axi_arready}, 32'h0);
      chk("rst_tready",  {31'b0, bus.s_axis_tready}, 32'h0);
      chk("rst_rvalid",  {31'b0, bus.s_axi_rvalid},  32'h0);
    end else begin
      chk("mdl_tready",  {31'b0, bus.s_axis_tready}, {31'b0, mq.size() != DEPTH});
      chk("mdl_arready", {31'b0, bus.s_axi_arready}, {31'b0, !m_busy});
      chk("mdl_rvalid",  {31'b0, bus.s_axi_rvalid},  {31'b0, m_busy});
      if (m_busy) begin
        chk("mdl_rdata", bus.s_axi_rdata, m_d);
        chk("mdl_rresp", {30'b0, bus.s_axi_rresp}, {30'b0, m_r});
      end
    end
  end

  task automatic push(input logic [31:0] d);
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    @(posedge aclk); #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                    input int hold, input string nm);
    bit got;
    bus.s_axi_araddr  = a;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      if (bus.s_axi_rvalid) begin
        got = 1;
        break;
      end
    end
    bus.s_axi_arvalid = 1'b0;
    chk({nm, "_rvalid_timeout"}, {31'b0, got}, 32'h1);
    chk({nm, "_rdata"}, bus.s_axi_rdata, ed);
    chk({nm, "_rresp"}, {30'b0, bus.s_axi_rresp}, {30'b0, er});
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      chk({nm, "_hold_rvalid"},  {31'b0, bus.s_axi_rvalid},  32'h1);
      chk({nm, "_hold_rdata"},   bus.s_axi_rdata, ed);
      chk({nm, "_hold_arready"}, {31'b0, bus.s_axi_arready}, 32'h0);
    end
    bus.s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    bus.s_axi_rready = 1'b0;
  endtask

  initial begin
    bus.s_axi_araddr  = 32'h0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;
    bus.s_axis_tdata  = 32'h0;
    bus.s_axis_tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk); #1;
    chk("idle_arready", {31'b0, bus.s_axi_arready}, 32'h1);
    chk("idle_tready",  {31'b0, bus.s_axis_tready}, 32'h1);
    chk("idle_rvalid",  {31'b0, bus.s_axi_rvalid},  32'h0);
    rd(32'h4, 32'h0, OKAY, 0, "status_reset");

    push(32'hA5A5_0001);
    push(32'hA5A5_0002);
    rd(32'h0, 32'hA5A5_0001, OKAY, 0, "pop1");
    rd(32'h0, 32'hA5A5_0002, OKAY, 0, "pop2");
    rd(32'h4, 32'h0, OKAY, 0, "status_drained");

    for (int i = 1; i <= 4; i++) push(32'h1000_0000 + 32'(i));
    chk("full_tready", {31'b0, bus.s_axis_tready}, 32'h0);
    rd(32'h4, 32'h8000_0004, OKAY, 0, "status_full");
    rd(32'h0, 32'h1000_0001, OKAY, 0, "pop_full");
    chk("after_pop_tready", {31'b0, bus.s_axis_tready}, 32'h1);
    for (int i = 2; i <= 4; i++) rd(32'h0, 32'h1000_0000 + 32'(i), OKAY, 0, "drain");

    push(32'h1234_5678);
    rd(32'h4, 32'h8000_0001, OKAY, 0, "status_one");
    rd(32'h0, 32'h1234_5678, OKAY, 5, "hold");
    rd(32'h4, 32'h0, OKAY, 0, "status_after_hold");

    push(32'hCAFE_F00D);
    rd(32'h8,  32'h0, SLVERR, 0, "unmapped_8");
    rd(32'h10, 32'h0, SLVERR, 0, "unmapped_10");
    rd(32'h4, 32'h8000_0001, OKAY, 0, "status_after_err");
    rd(32'h0, 32'hCAFE_F00D, OKAY, 0, "pop_cafe");

    rd(32'h0, 32'h0, EMPTY_RESP, 0, "empty_read");
    rd(32'h4, 32'h0, OKAY, 0, "status_empty");

    // Stream held valid while full: pop blocks the push that edge, refills next.
    bus.s_axis_tdata  = 32'h0000_0077;
    bus.s_axis_tvalid = 1'b1;
    repeat (6) @(posedge aclk);
    #1;
    rd(32'h0, 32'h0000_0077, OKAY, 0, "stream_pop");
    rd(32'h4, 32'h8000_0004, OKAY, 0, "stream_refill");
    bus.s_axis_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) rd(32'h0, 32'h0000_0077, OKAY, 0, "stream_drain");

    push(32'h0000_0055);
    bus.s_axi_araddr  = 32'h0;
    bus.s_axi_arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      if (bus.s_axi_rvalid) break;
    end
    bus.s_axi_arvalid = 1'b0;
    chk("pre_reset_rvalid", {31'b0, bus.s_axi_rvalid}, 32'h1);
    #2 areset = 1'b1;
    #1;
    chk("async_rvalid",  {31'b0, bus.s_axi_rvalid},  32'h0);
    chk("async_arready", {31'b0, bus.s_axi_arready}, 32'h0);
    chk("async_tready",  {31'b0, bus.s_axis_tready}, 32'h0);
    @(posedge aclk); #1 areset = 1'b0;
    bus.s_axi_rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 bus.s_axi_rready = 1'b0;
    rd(32'h4, 32'h0, OKAY, 0, "status_post_reset");

    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
